// File: rtl/serial_sub.sv
// Digit-serial subtractor: computes (a - b - bi) mod 2^N, W bits per clock,
// with a registered borrow between slices and a start/busy/done handshake.
module serial_sub #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_bi,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_diff,
    output logic         o_bo,
    output logic         o_ovf
);

    localparam int S  = N / W;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    generate
        if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_param
            $error("serial_sub: illegal N/W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_load;
    logic            w_step;
    logic            w_last;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_dreg;
    logic            r_borrow;
    logic [CW-1:0]   r_cnt;
    logic            r_a_msb;
    logic            r_b_msb;

    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_diff;
    logic            r_bo;
    logic            r_ovf;

    logic [W:0]      w_slice;
    logic [N+W-1:0]  w_dcat;
    logic [N-1:0]    w_dreg_next;
    logic            w_ovf;

    // Next-state decode and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = (r_cnt == LAST);
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // One slice of subtraction; the extra top bit of the W+1 result is the borrow out
    always_comb begin
        w_slice     = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_borrow};
        w_dcat      = {w_slice[W-1:0], r_dreg};
        w_dreg_next = w_dcat[N+W-1:W];
        w_ovf       = (r_a_msb != r_b_msb) && (w_dreg_next[N-1] != r_a_msb);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered handshake outputs, decoded from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_RUN);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    // Operand shift registers, borrow chain, slice counter and result capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= {N{1'b0}};
            r_b      <= {N{1'b0}};
            r_dreg   <= {N{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= {N{1'b0}};
            r_bo     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bi;
            r_cnt    <= {CW{1'b0}};
            r_a_msb  <= i_a[N-1];
            r_b_msb  <= i_b[N-1];
        end else if (w_step) begin
            r_a      <= r_a >> W;
            r_b      <= r_b >> W;
            r_dreg   <= w_dreg_next;
            r_borrow <= w_slice[W];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_dreg_next;
                r_bo   <= w_slice[W];
                r_ovf  <= w_ovf;
            end else begin
                r_diff <= r_diff;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_diff = r_diff;
    assign o_bo   = r_bo;
    assign o_ovf  = r_ovf;

endmodule
